// File: rtl/latch_capture_ctrl_if.sv
// Handshake bundle between the latch capture controller and its environment.
// master: the controller (drives start/frame status); slave: the latch bank,
// requester and frame consumer side.
interface latch_capture_ctrl_if #(
  parameter int GW = 8,
  parameter int CW = 16
) ();
  logic          cap_req;
  logic          auto_mode;
  logic [GW-1:0] gap_cycles;
  logic          abort;
  logic          err_clr;
  logic          latch_done;
  logic          start_o;
  logic          busy;
  logic          frame_valid;
  logic          frame_ready;
  logic [CW-1:0] frame_cnt;
  logic          err_timeout;

  modport master (
    input  cap_req, auto_mode, gap_cycles, abort, err_clr, latch_done, frame_ready,
    output start_o, busy, frame_valid, frame_cnt, err_timeout
  );

  modport slave (
    output cap_req, auto_mode, gap_cycles, abort, err_clr, latch_done, frame_ready,
    input  start_o, busy, frame_valid, frame_cnt, err_timeout
  );
endinterface

// File: rtl/latch_capture_ctrl.sv
// Sequencing controller for the shift-triggered latch bank: fires a one-cycle
// start pulse, waits for the last-stage trigger, then offers the captured
// frame over valid/ready. Supports auto-repeat with a programmable gap,
// synchronous abort and a sticky timeout flag. All outputs are registered.
module latch_capture_ctrl #(
  parameter int STAGE = 8,
  parameter int SLACK = 4,
  parameter int GW    = 8,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  latch_capture_ctrl_if.master bus
);

  // Last cycle count at which a done edge is still accepted.
  localparam int TMO = STAGE + 1 + SLACK;
  localparam int WW  = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t        state, state_next;
  logic          start, start_next;
  logic          valid, valid_next;
  logic          busy, busy_next;
  logic          err, err_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [WW-1:0] wait_cnt, wait_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic          done_prev;
  logic          done_rise;

  assign done_rise = bus.latch_done & ~done_prev;

  // State and registered outputs; async reset returns everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      start     <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      done_prev <= 1'b0;
    end else begin
      state     <= state_next;
      start     <= start_next;
      valid     <= valid_next;
      busy      <= busy_next;
      err       <= err_next;
      cnt       <= cnt_next;
      wait_cnt  <= wait_next;
      gap_cnt   <= gap_next;
      done_prev <= bus.latch_done;
    end
  end

  // Next-state and output logic; abort overrides every state transition.
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    valid_next = valid;
    cnt_next   = cnt;
    wait_next  = wait_cnt;
    gap_next   = gap_cnt;
    // Clear first so a timeout detected below at the same edge wins.
    err_next   = bus.err_clr ? 1'b0 : err;

    if (bus.abort) begin
      state_next = IDLE;
      valid_next = 1'b0;
      wait_next  = '0;
      gap_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          valid_next = 1'b0;
          if (bus.cap_req) begin
            state_next = CAPTURE;
            start_next = 1'b1;
            wait_next  = '0;
          end
        end
        CAPTURE: begin
          wait_next = wait_cnt + WW'(1);
          if (done_rise) begin
            state_next = HOLD;
            valid_next = 1'b1;
          end else if (wait_cnt == WW'(TMO - 1)) begin
            state_next = IDLE;
            err_next   = 1'b1;
            wait_next  = '0;
          end
        end
        HOLD: begin
          if (bus.frame_ready) begin
            valid_next = 1'b0;
            cnt_next   = cnt + CW'(1);
            if (!bus.auto_mode) begin
              state_next = IDLE;
            end else if (bus.gap_cycles == '0) begin
              // Zero gap: restart immediately after the accepting edge.
              state_next = CAPTURE;
              start_next = 1'b1;
              wait_next  = '0;
            end else begin
              state_next = GAP;
              gap_next   = bus.gap_cycles;
            end
          end
        end
        GAP: begin
          // GAP lasts exactly gap_cycles cycles before the next start.
          if (gap_cnt <= GW'(1)) begin
            gap_next = '0;
            if (bus.auto_mode) begin
              state_next = CAPTURE;
              start_next = 1'b1;
              wait_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            gap_next = gap_cnt - GW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Busy tracks the registered state one-for-one.
  always_comb begin
    busy_next = (state_next != IDLE);
  end

  assign bus.start_o     = start;
  assign bus.busy        = busy;
  assign bus.frame_valid = valid;
  assign bus.frame_cnt   = cnt;
  assign bus.err_timeout = err;

endmodule

// File: tb/tb_latch_capture_ctrl.sv
// Directed bench for latch_capture_ctrl with a shift-register latch model.
// Built with CW=4 so the frame counter wrap is reachable quickly.
module tb_latch_capture_ctrl;
  localparam int STAGE = 8;
  localparam int SLACK = 4;
  localparam int GW    = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst;
  logic model_en;
  logic [STAGE:0] sr;

  int passes = 0;
  int total  = 0;

  latch_capture_ctrl_if #(.GW(GW), .CW(CW)) bus ();

  latch_capture_ctrl #(.STAGE(STAGE), .SLACK(SLACK), .GW(GW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Latch trigger chain: done rises STAGE+1 cycles after start_o is high.
  always @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGE-1:0], bus.start_o};
  end
  assign bus.latch_done = model_en & sr[STAGE];

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One-cycle capture request; returns in the cycle where start_o should be high.
  task automatic kick();
    bus.cap_req = 1'b1;
    step(1);
    bus.cap_req = 1'b0;
  endtask

  // Counts cycles until the next start_o pulse, bounded at 100.
  task automatic wait_start(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.start_o && n < 100);
  endtask

  initial begin
    int n;
    int hi;
    int starts;
    bit seen15;
    bit wrapped;

    rst = 1'b1;
    model_en = 1'b1;
    bus.cap_req = 0; bus.auto_mode = 0; bus.gap_cycles = '0;
    bus.abort = 0; bus.err_clr = 0; bus.frame_ready = 1;
    step(2);
    chk("rst_start", bus.start_o, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.frame_valid, 0);
    chk("rst_cnt", bus.frame_cnt, 0);
    chk("rst_err", bus.err_timeout, 0);
    rst = 1'b0;
    step(1);

    // Single shot, consumer always ready.
    kick();
    chk("ss_start", bus.start_o, 1);
    chk("ss_busy", bus.busy, 1);
    step(1);
    chk("ss_start_once", bus.start_o, 0);
    step(8);
    chk("ss_valid_early", bus.frame_valid, 0);
    step(1);
    chk("ss_valid_at10", bus.frame_valid, 1);
    step(1);
    chk("ss_valid_drop", bus.frame_valid, 0);
    chk("ss_cnt", bus.frame_cnt, 1);
    chk("ss_busy_after", bus.busy, 0);
    $display("single shot done cnt=%0d", bus.frame_cnt);

    // Backpressure: ready low for 20 valid cycles.
    bus.frame_ready = 0;
    kick();
    step(10);
    hi = 0; starts = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.frame_valid) hi++;
      if (bus.start_o) starts++;
      if (i == 19) bus.frame_ready = 1;
      step(1);
    end
    chk("bp_valid_held", hi, 20);
    chk("bp_valid_drop", bus.frame_valid, 0);
    chk("bp_cnt", bus.frame_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      if (bus.start_o) starts++;
      step(1);
    end
    chk("bp_no_start", starts, 0);
    $display("backpressure done cnt=%0d", bus.frame_cnt);

    // Auto mode, gap 3: start spacing STAGE+3+3 = 14.
    bus.auto_mode = 1; bus.gap_cycles = 8'd3;
    kick();
    for (int f = 0; f < 3; f++) begin
      wait_start(n);
      chk("auto3_spacing", n, 14);
    end
    bus.auto_mode = 0;
    step(12);
    chk("auto3_cnt", bus.frame_cnt, 6);
    chk("auto3_idle", bus.busy, 0);
    $display("auto gap3 done cnt=%0d", bus.frame_cnt);

    // Auto mode, gap 0: start follows the accept edge directly.
    bus.auto_mode = 1; bus.gap_cycles = 8'd0;
    kick();
    wait_start(n);
    chk("auto0_spacing", n, 11);
    bus.auto_mode = 0;
    step(12);
    chk("auto0_cnt", bus.frame_cnt, 8);
    $display("auto gap0 done cnt=%0d", bus.frame_cnt);

    // Auto mode dropped during GAP: finish to IDLE, no restart.
    bus.auto_mode = 1; bus.gap_cycles = 8'd5;
    kick();
    step(11);
    bus.auto_mode = 0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.start_o) starts++;
      step(1);
    end
    chk("gapdrop_no_start", starts, 0);
    chk("gapdrop_idle", bus.busy, 0);
    chk("gapdrop_cnt", bus.frame_cnt, 9);
    $display("gap drop done cnt=%0d", bus.frame_cnt);

    // Timeout: latch never answers.
    model_en = 0;
    kick();
    step(12);
    chk("to_not_yet", bus.err_timeout, 0);
    step(1);
    chk("to_set", bus.err_timeout, 1);
    chk("to_idle", bus.busy, 0);
    chk("to_no_valid", bus.frame_valid, 0);
    kick();
    chk("to_start_ok", bus.start_o, 1);
    chk("to_sticky", bus.err_timeout, 1);
    step(12);
    bus.err_clr = 1;
    step(1);
    chk("to_set_wins", bus.err_timeout, 1);
    step(1);
    chk("to_cleared", bus.err_timeout, 0);
    bus.err_clr = 0;
    model_en = 1;
    $display("timeout done err=%0d", bus.err_timeout);

    // Abort in CAPTURE; the late done pulse must not create a frame.
    kick();
    step(4);
    bus.abort = 1;
    step(1);
    bus.abort = 0;
    chk("abc_idle", bus.busy, 0);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.frame_valid) hi++;
      step(1);
    end
    chk("abc_no_valid", hi, 0);
    chk("abc_cnt", bus.frame_cnt, 9);
    $display("abort capture done cnt=%0d", bus.frame_cnt);

    // Abort in HOLD with ready high: abort wins, count unchanged.
    bus.frame_ready = 0;
    kick();
    step(10);
    chk("abh_valid", bus.frame_valid, 1);
    bus.frame_ready = 1; bus.abort = 1;
    step(1);
    bus.abort = 0;
    chk("abh_valid_drop", bus.frame_valid, 0);
    chk("abh_idle", bus.busy, 0);
    chk("abh_cnt", bus.frame_cnt, 9);
    step(2);
    chk("abh_cnt_later", bus.frame_cnt, 9);
    $display("abort hold done cnt=%0d", bus.frame_cnt);

    // Asynchronous reset while holding a frame.
    bus.frame_ready = 0;
    kick();
    step(10);
    chk("rh_valid", bus.frame_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rh_valid0", bus.frame_valid, 0);
    chk("rh_busy0", bus.busy, 0);
    chk("rh_cnt0", bus.frame_cnt, 0);
    chk("rh_start0", bus.start_o, 0);
    step(1);
    rst = 1'b0;
    step(1);
    $display("reset mid-hold done cnt=%0d", bus.frame_cnt);

    // Counter wrap 15 -> 0 over 16 auto frames.
    bus.frame_ready = 1; bus.auto_mode = 1; bus.gap_cycles = 8'd0;
    seen15 = 0; wrapped = 0;
    kick();
    for (int i = 0; i < 400 && !wrapped; i++) begin
      if (bus.frame_cnt == 4'd15) begin
        seen15 = 1;
        bus.auto_mode = 0;
      end
      if (seen15 && bus.frame_cnt == 4'd0) wrapped = 1;
      step(1);
    end
    chk("wrap_seen", wrapped, 1);
    step(3);
    chk("wrap_cnt", bus.frame_cnt, 0);
    chk("wrap_idle", bus.busy, 0);
    $display("wrap done cnt=%0d", bus.frame_cnt);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
